// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encoding, responder FSM states and lane helpers.
package mem_pkg;
    typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10} size_t;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESPOND} state_t;

    // The reserved encoding 11 behaves as a word access.
    function automatic size_t size_of(logic [1:0] s);
        return s == 2'b00 ? SIZE_BYTE : s == 2'b01 ? SIZE_HALF : SIZE_WORD;
    endfunction

    function automatic logic [1:0] align(size_t s, logic [1:0] a);
        return s == SIZE_BYTE ? a : s == SIZE_HALF ? {a[1], 1'b0} : 2'b00;
    endfunction

    function automatic logic [3:0] byte_en(size_t s, logic [1:0] a);
        return s == SIZE_BYTE ? 4'b0001 << a : s == SIZE_HALF ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    endfunction

    function automatic logic [31:0] store_data(size_t s, logic [31:0] d);
        return s == SIZE_BYTE ? {4{d[7:0]}} : s == SIZE_HALF ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [31:0] load_data(size_t s, logic [1:0] a, logic u, logic [31:0] q);
        logic [7:0] b;
        logic [15:0] h;
        b = q[{a, 3'b000} +: 8];
        h = a[1] ? q[31:16] : q[15:0];
        return s == SIZE_BYTE ? {{24{~u & b[7]}}, b} : s == SIZE_HALF ? {{16{~u & h[15]}}, h} : q;
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response channel between memory stage and data memory.
interface dmem_responder_if;
    logic        i_ReqValid;
    logic        o_ReqReady;
    logic        i_ReqWrite;
    logic [1:0]  i_ReqSize;
    logic        i_ReqUnsigned;
    logic [31:0] i_ReqAddr;
    logic [31:0] i_ReqWData;
    logic        o_RspValid;
    logic        i_RspReady;
    logic [31:0] o_RspData;
    logic        o_RspError;

    modport master (
        output i_ReqValid, i_ReqWrite, i_ReqSize, i_ReqUnsigned, i_ReqAddr, i_ReqWData, i_RspReady,
        input  o_ReqReady, o_RspValid, o_RspData, o_RspError
    );
    modport slave (
        input  i_ReqValid, i_ReqWrite, i_ReqSize, i_ReqUnsigned, i_ReqAddr, i_ReqWData, i_RspReady,
        output o_ReqReady, o_RspValid, o_RspData, o_RspError
    );
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, 32-bit words, 4 byte enables, 1-cycle read.
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[addr];
        end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data memory responder with byte/half/word lanes.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned accesses return an error instead of being aligned.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input logic              i_Clock,
    input logic              i_Reset,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t state, next;
    logic [3:0] cnt;
    logic wr, uns, ready, accept, mis;
    logic [1:0] sz, off;
    logic [AW+1:0] addr;
    logic [31:0] wdata, q, rsp_data;
    logic rsp_valid, rsp_error;
    size_t esz;
    logic unused_addr;

    assign unused_addr = ^bus.i_ReqAddr[31:AW+2];
    assign ready = state == IDLE && i_Reset;
    assign accept = ready && bus.i_ReqValid;
    assign bus.o_ReqReady = ready;
    assign bus.o_RspValid = rsp_valid;
    assign bus.o_RspData = rsp_data;
    assign bus.o_RspError = rsp_error;

    always_comb begin
        esz = size_of(sz);
        off = align(esz, addr[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = off != addr[1:0];
`else
        mis = 1'b0;
`endif
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? (WS == 4'd0 ? ACCESS : WAIT) : IDLE;
            WAIT:    next = cnt == 4'd1 ? ACCESS : WAIT;
            ACCESS:  next = RESPOND;
            RESPOND: next = rsp_valid && bus.i_RspReady ? IDLE : RESPOND;
            default: next = IDLE;
        endcase
    end

    // The RAM reads at the ACCESS->RESPOND edge; its output is registered one edge later.
    always_ff @(posedge i_Clock or negedge i_Reset)
        if (!i_Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wr        <= 1'b0;
            sz        <= '0;
            uns       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                cnt   <= WS;
                wr    <= bus.i_ReqWrite;
                sz    <= bus.i_ReqSize;
                uns   <= bus.i_ReqUnsigned;
                addr  <= bus.i_ReqAddr[AW+1:0];
                wdata <= bus.i_ReqWData;
            end else if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (state == RESPOND && !rsp_valid) begin
                rsp_valid <= 1'b1;
                rsp_error <= mis;
                rsp_data  <= wr || mis ? '0 : load_data(esz, off, uns, q);
            end else if (state == RESPOND && bus.i_RspReady) begin
                rsp_valid <= 1'b0;
                rsp_error <= 1'b0;
                rsp_data  <= '0;
            end
        end

    dmem_ram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk   (i_Clock),
        .en    (state == ACCESS && !mis),
        .we    (wr),
        .be    (byte_en(esz, off)),
        .addr  (addr[AW+1:2]),
        .wdata (store_data(esz, wdata)),
        .rdata (q)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of latency, lanes, backpressure, wrap, alignment and reset.
module tb_dmem_responder;
    localparam int WS = 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] data;
    logic err;
    int lat;

    dmem_responder_if bus();
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (.i_Clock(clk), .i_Reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic xfer(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic re, output int l);
        int b;
        @(negedge clk);
        bus.i_ReqValid = 1'b1;
        bus.i_ReqWrite = w;
        bus.i_ReqSize = s;
        bus.i_ReqUnsigned = u;
        bus.i_ReqAddr = a;
        bus.i_ReqWData = d;
        b = 0;
        while (!bus.o_ReqReady && b < 20) begin
            @(negedge clk);
            b++;
        end
        @(posedge clk);
        #1 bus.i_ReqValid = 1'b0;
        l = 0;
        while (!bus.o_RspValid && l < 50) begin
            @(posedge clk);
            #1 l++;
        end
        rd = bus.o_RspData;
        re = bus.o_RspError;
        bus.i_RspReady = 1'b1;
        @(posedge clk);
        #1 bus.i_RspReady = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (bus.o_ReqReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", bus.o_ReqReady); end
        n_checks++; if (bus.o_RspValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.o_RspValid); end
        n_checks++; if (bus.o_RspData !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", bus.o_RspData); end
        n_checks++; if (bus.o_RspError !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b exp 0", bus.o_RspError); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.o_ReqReady !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b exp 1", bus.o_ReqReady); end
    endtask

    task automatic test_word;
        xfer(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, data, err, lat);
        n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL store_data got %h exp 0", data); end
        n_checks++; if (lat !== WS + 2) begin n_fail++; $display("FAIL store_latency got %0d exp %0d", lat, WS + 2); end
        xfer(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_load got %h exp deadbeef", data); end
        n_checks++; if (lat !== WS + 2) begin n_fail++; $display("FAIL load_latency got %0d exp %0d", lat, WS + 2); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL word_error got %b exp 0", err); end
    endtask

    task automatic test_subword;
        xfer(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, data, err, lat);
        xfer(1'b1, 2'b00, 1'b0, 32'h203, 32'h00000080, data, err, lat);
        xfer(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL sbyte_load got %h exp ffffff80", data); end
        xfer(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'h00000080) begin n_fail++; $display("FAIL ubyte_load got %h exp 00000080", data); end
        xfer(1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, data, err, lat);
        xfer(1'b0, 2'b00, 1'b1, 32'h200, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'h00000044) begin n_fail++; $display("FAIL byte0_kept got %h exp 00000044", data); end
        xfer(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'h00001234) begin n_fail++; $display("FAIL half_load got %h exp 00001234", data); end
        xfer(1'b0, 2'b00, 1'b0, 32'h201, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'h00000033) begin n_fail++; $display("FAIL byte1_load got %h exp 00000033", data); end
        xfer(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'h12343344) begin n_fail++; $display("FAIL size11_load got %h exp 12343344", data); end
    endtask

    task automatic test_backpressure;
        int l;
        @(negedge clk);
        bus.i_ReqValid = 1'b1;
        bus.i_ReqWrite = 1'b0;
        bus.i_ReqSize = 2'b10;
        bus.i_ReqAddr = 32'h100;
        @(posedge clk);
        #1 bus.i_ReqValid = 1'b0;
        l = 0;
        while (!bus.o_RspValid && l < 50) begin
            @(posedge clk);
            #1 l++;
        end
        bus.i_ReqAddr = 32'h200;
        bus.i_ReqValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus.o_RspValid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, bus.o_RspValid); end
            n_checks++; if (bus.o_RspData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp deadbeef", i, bus.o_RspData); end
            n_checks++; if (bus.o_ReqReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, bus.o_ReqReady); end
        end
        bus.i_RspReady = 1'b1;
        @(posedge clk);
        #1 bus.i_RspReady = 1'b0;
        n_checks++; if (bus.o_RspValid !== 1'b0) begin n_fail++; $display("FAIL hs_valid got %b exp 0", bus.o_RspValid); end
        n_checks++; if (bus.o_ReqReady !== 1'b1) begin n_fail++; $display("FAIL hs_ready got %b exp 1", bus.o_ReqReady); end
        @(posedge clk);
        #1 bus.i_ReqValid = 1'b0;
        n_checks++; if (bus.o_ReqReady !== 1'b0) begin n_fail++; $display("FAIL queued_accept got %b exp 0", bus.o_ReqReady); end
        l = 0;
        while (!bus.o_RspValid && l < 50) begin
            @(posedge clk);
            #1 l++;
        end
        n_checks++; if (l !== WS + 2) begin n_fail++; $display("FAIL queued_latency got %0d exp %0d", l, WS + 2); end
        n_checks++; if (bus.o_RspData !== 32'h12343344) begin n_fail++; $display("FAIL queued_data got %h exp 12343344", bus.o_RspData); end
        bus.i_RspReady = 1'b1;
        @(posedge clk);
        #1 bus.i_RspReady = 1'b0;
    endtask

    task automatic test_wrap;
        xfer(1'b1, 2'b10, 1'b0, 32'h1000, 32'h00000011, data, err, lat);
        xfer(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'h00000011) begin n_fail++; $display("FAIL wrap_load got %h exp 00000011", data); end
    endtask

    task automatic test_misalign;
        xfer(1'b1, 2'b10, 1'b0, 32'h100, 32'hAABBCCDD, data, err, lat);
        xfer(1'b1, 2'b01, 1'b0, 32'h101, 32'h00005566, data, err, lat);
        n_checks++; if (lat !== WS + 2) begin n_fail++; $display("FAIL mis_latency got %0d exp %0d", lat, WS + 2); end
`ifdef DMEM_MISALIGN_TRAP_EN
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL mis_error got %b exp 1", err); end
        xfer(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'hAABBCCDD) begin n_fail++; $display("FAIL mis_unchanged got %h exp aabbccdd", data); end
        xfer(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, data, err, lat);
        n_checks++; if (err !== 1'b1 || data !== 32'h0) begin n_fail++; $display("FAIL mis_load got %b/%h exp 1/0", err, data); end
`else
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mis_error got %b exp 0", err); end
        xfer(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'hAABB5566) begin n_fail++; $display("FAIL mis_aligned got %h exp aabb5566", data); end
        xfer(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'hAABB5566) begin n_fail++; $display("FAIL mis_load got %h exp aabb5566", data); end
`endif
    endtask

    task automatic test_reset_wait;
        xfer(1'b1, 2'b10, 1'b0, 32'h300, 32'h01020304, data, err, lat);
        @(negedge clk);
        bus.i_ReqValid = 1'b1;
        bus.i_ReqWrite = 1'b1;
        bus.i_ReqSize = 2'b10;
        bus.i_ReqAddr = 32'h300;
        bus.i_ReqWData = 32'hFFFFFFFF;
        @(posedge clk);
        #1 bus.i_ReqValid = 1'b0;
        rst_n = 1'b0;
        #2;
        n_checks++; if (bus.o_ReqReady !== 1'b0) begin n_fail++; $display("FAIL rw_ready got %b exp 0", bus.o_ReqReady); end
        n_checks++; if (bus.o_RspValid !== 1'b0) begin n_fail++; $display("FAIL rw_valid got %b exp 0", bus.o_RspValid); end
        n_checks++; if (bus.o_RspData !== 32'h0 || bus.o_RspError !== 1'b0) begin n_fail++; $display("FAIL rw_data got %h/%b exp 0/0", bus.o_RspData, bus.o_RspError); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, data, err, lat);
        n_checks++; if (data !== 32'h01020304) begin n_fail++; $display("FAIL rw_old_data got %h exp 01020304", data); end
    endtask

    initial begin
        bus.i_ReqValid = 1'b0;
        bus.i_ReqWrite = 1'b0;
        bus.i_ReqSize = 2'b00;
        bus.i_ReqUnsigned = 1'b0;
        bus.i_ReqAddr = 32'h0;
        bus.i_ReqWData = 32'h0;
        bus.i_RspReady = 1'b0;
        test_reset();
        test_word();
        test_subword();
        test_backpressure();
        test_wrap();
        test_misalign();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the data RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the extra stall cycles before each RAM access (0..15).
REQ-003 SHALL have port i_Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports i_ReqValid (in, 1), o_ReqReady (out, 1), i_ReqWrite (in, 1), i_ReqSize (in, 2; 00 byte, 01 half, 10 word), i_ReqUnsigned (in, 1), i_ReqAddr (in, 32) and i_ReqWData (in, 32): the request from the memory stage.
REQ-006 SHALL have ports o_RspValid (out, 1), i_RspReady (in, 1), o_RspData (out, 32) and o_RspError (out, 1): the response to the memory stage.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, ACCESS and RESPOND.
REQ-008 SHALL drive o_ReqReady high only in IDLE with reset deasserted; a request is accepted on an edge where i_ReqValid and o_ReqReady are both high.
REQ-009 SHALL, on acceptance, register all request fields and go to WAIT with the counter loaded to WAIT_STATES, or go straight to ACCESS when WAIT_STATES is 0.
REQ-010 SHALL decrement the counter once per cycle in WAIT and move to ACCESS on the edge where it reaches 0.
REQ-011 SHALL perform exactly one RAM operation in ACCESS, then go to RESPOND.
REQ-012 SHALL raise o_RspValid exactly WAIT_STATES+2 edges after the accept edge.
REQ-013 SHALL hold o_RspValid, o_RspData and o_RspError stable in RESPOND until i_RspReady is sampled high, then return to IDLE.
REQ-014 SHALL NOT accept a new request in the handshake cycle; o_ReqReady rises on the following cycle.
REQ-015 SHALL form the word index from i_ReqAddr[log2(DEPTH_WORDS)+1:2] and ignore upper address bits, so addresses wrap modulo the RAM size.
REQ-016 SHALL store with byte enables: byte = 1<<addr[1:0] with data byte replicated; half = 0011<<(2*addr[1]) with data half replicated; word = 1111.
REQ-017 SHALL extract loads by lane, selecting byte addr[1:0] or half addr[1], and sign-extend unless i_ReqUnsigned is set.
REQ-018 SHALL return o_RspData = 0 for stores.
REQ-019 SHALL treat i_ReqSize = 11 as word.

Reset
REQ-020 SHALL, while i_Reset is low, force state IDLE, counter 0, o_ReqReady 0, o_RspValid 0, o_RspData 0 and o_RspError 0.
REQ-021 SHALL, on reset mid-operation, abort immediately; a store not yet in ACCESS is never written, and RAM contents are never cleared by reset.

Configuration
REQ-022 SHALL, with macro DMEM_MISALIGN_TRAP_EN defined, treat a half with addr[0]=1 or a word with addr[1:0]!=0 as misaligned.
REQ-023 SHALL, for a misaligned request, perform no RAM access (stores dropped) and respond with o_RspError=1 and o_RspData=0 at the same latency as REQ-012.
REQ-024 SHALL, without DMEM_MISALIGN_TRAP_EN, force misaligned addresses to alignment (clear addr[0] for half, addr[1:0] for word) and tie o_RspError to 0.

Structure
REQ-025 SHALL take the size encoding enum (SIZE_BYTE/SIZE_HALF/SIZE_WORD) and the FSM state typedef from shared package mem_pkg.
REQ-026 SHALL instantiate one sub-module, dmem_ram: a single-port synchronous RAM with 4 byte enables and 1-cycle read.

Verification
REQ-027 SHALL verify word store then load: store 0xDEADBEEF at 0x100, then load word at 0x100 -> o_RspData 0xDEADBEEF, o_RspValid 3 edges after accept (WAIT_STATES=1).
REQ-028 SHALL verify sub-word loads: byte store 0x80 at 0x203, then signed byte load -> 0xFFFFFF80, unsigned -> 0x00000080; half store 0x1234 at 0x202 leaves byte 0x200 unchanged.
REQ-029 SHALL verify backpressure: i_RspReady low for 5 cycles -> response held stable, o_ReqReady low, a queued request is accepted only after the handshake plus one cycle.
REQ-030 SHALL verify wrap: DEPTH_WORDS=1024, store 0x11 at 0x1000 -> word load at 0x0 returns 0x00000011.
REQ-031 SHALL verify misalignment: half store at 0x101 -> with macro, o_RspError=1 and memory unchanged; without macro, the data lands at 0x100.
REQ-032 SHALL verify reset in WAIT: assert i_Reset low during a store's WAIT -> later load shows old data, and all outputs are 0 during reset.
